// File: rtl/button_debounce_arbiter.sv
// Debounces N buttons with one shared stability counter, lent to one
// pending button at a time by a round-robin SCAN/TRACK state machine.
//
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous, active-high reset
//   ButtonIn    [N-1:0] raw, asynchronous, bouncing button levels
//   ButtonOut   [N-1:0] one-cycle pulse per debounced press (0->1 commit)
//   ButtonLevel [N-1:0] debounced level per button
//   Busy        high while the counter is granted (state TRACK)
//   GrantIdx    index of the current or last granted button
module button_debounce_arbiter #(
  parameter int N        = 4,
  parameter bit sim      = 1'b0,
  parameter int CNT_SIM  = 200,
  parameter int CNT_REAL = 2000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         ButtonIn,
  output logic [N-1:0]         ButtonOut,
  output logic [N-1:0]         ButtonLevel,
  output logic                 Busy,
  output logic [$clog2(N)-1:0] GrantIdx
);

  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(CNT_REAL);
  localparam int CNT = sim ? CNT_SIM : CNT_REAL;

  localparam logic [CW-1:0] CNT_M1  = CW'(CNT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  localparam logic [0:0] SCAN  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [N-1:0]  sync1_q;
  logic [N-1:0]  sync2_q;
  logic [N-1:0]  lvl_q,   lvl_d;
  logic [N-1:0]  out_q,   out_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [0:0]    state_q, state_d;

  logic [N-1:0]  pend;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  assign pend = sync2_q ^ lvl_q;

  // Round-robin search starting one past the last grant. The candidate
  // wraps explicitly so non-power-of-two N never indexes past N-1.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    cand  = grant_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IDX_MAX) ? '0 : cand + 1'b1;
      if (!found && pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    out_d   = '0;
    unique case (state_q)
      SCAN: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (sync2_q[grant_q] == lvl_q[grant_q]) begin
          // Bounced back to the committed level: give up the grant.
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == CNT_M1) begin
          lvl_d[grant_q] = sync2_q[grant_q];
          // Only a press pulses; a release just moves the level.
          out_d[grant_q] = sync2_q[grant_q];
          cnt_d          = '0;
          state_d        = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      out_q   <= '0;
      grant_q <= IDX_MAX;
      cnt_q   <= '0;
      state_q <= SCAN;
    end else begin
      sync1_q <= ButtonIn;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      out_q   <= out_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign ButtonOut   = out_q;
  assign ButtonLevel = lvl_q;
  assign Busy        = (state_q == TRACK);
  assign GrantIdx    = grant_q;

endmodule

// File: tb/tb_button_debounce_arbiter.sv
// Directed bench for button_debounce_arbiter with sim=1 (CNT=200), N=4.
// Each scenario task drives buttons cycle by cycle and checks inline.
module tb_button_debounce_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] bout;
  logic [3:0] blvl;
  logic       busy;
  logic [1:0] gidx;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int pcount [4];
  int first_pulse [4];
  int fall_cnt [4];
  int fall_cyc [4];
  int wide_err;
  int busy_cnt;
  logic [3:0] prev_out;
  logic [3:0] prev_lvl;
  int t0;
  int d;

  button_debounce_arbiter #(
    .N(4), .sim(1'b1), .CNT_SIM(200), .CNT_REAL(2000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ButtonIn(btn),
    .ButtonOut(bout),
    .ButtonLevel(blvl),
    .Busy(busy),
    .GrantIdx(gidx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_rec();
    for (int i = 0; i < 4; i++) begin
      pcount[i] = 0;
      first_pulse[i] = -100000;
      fall_cnt[i] = 0;
      fall_cyc[i] = -100000;
    end
    wide_err = 0;
    busy_cnt = 0;
    prev_out = bout;
    prev_lvl = blvl;
  endtask

  // Sample outputs at the falling edge, then apply the next input value.
  task automatic step(input logic [3:0] b);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (bout[i]) begin
        if (pcount[i] == 0) first_pulse[i] = cyc;
        pcount[i]++;
        if (prev_out[i]) wide_err++;
      end
      if (prev_lvl[i] && !blvl[i]) begin
        fall_cnt[i]++;
        fall_cyc[i] = cyc;
      end
    end
    if (busy) busy_cnt++;
    prev_out = bout;
    prev_lvl = blvl;
    btn = b;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    repeat (n) step(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn = 4'b0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_rec();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bout !== 4'b0000) begin
      errors++;
      $display("FAIL rst_out: got %b expected 0000", bout);
    end
    checks++;
    if (blvl !== 4'b0000) begin
      errors++;
      $display("FAIL rst_lvl: got %b expected 0000", blvl);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b expected 0", busy);
    end
    checks++;
    if (gidx !== 2'd3) begin
      errors++;
      $display("FAIL rst_gidx: got %0d expected 3", gidx);
    end
    reset = 1'b0;
  endtask

  task automatic test_press_bounce();
    do_reset();
    for (int p = 0; p < 25; p++) begin
      hold(4'b0001, 5);
      hold(4'b0000, 5);
    end
    step(4'b0001);
    t0 = cyc + 1;
    hold(4'b0001, 899);
    checks++;
    if (pcount[0] !== 1) begin
      errors++;
      $display("FAIL t1_count: got %0d pulses expected 1", pcount[0]);
    end
    d = first_pulse[0] - t0;
    checks++;
    if (d !== 202) begin
      errors++;
      $display("FAIL t1_latency: got %0d expected 202", d);
    end
    checks++;
    if (wide_err !== 0) begin
      errors++;
      $display("FAIL t1_width: got %0d wide pulses expected 0", wide_err);
    end
    checks++;
    if (blvl !== 4'b0001) begin
      errors++;
      $display("FAIL t1_level: got %b expected 0001", blvl);
    end
  endtask

  task automatic test_release_bounce();
    clear_rec();
    for (int p = 0; p < 25; p++) begin
      hold(4'b0000, 5);
      hold(4'b0001, 5);
    end
    step(4'b0000);
    t0 = cyc + 1;
    hold(4'b0000, 1199);
    checks++;
    if (fall_cnt[0] !== 1) begin
      errors++;
      $display("FAIL t2_falls: got %0d expected 1", fall_cnt[0]);
    end
    d = fall_cyc[0] - t0;
    checks++;
    if (d !== 202) begin
      errors++;
      $display("FAIL t2_latency: got %0d expected 202", d);
    end
    d = pcount[0] + pcount[1] + pcount[2] + pcount[3];
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL t2_pulses: got %0d expected 0", d);
    end
    checks++;
    if (blvl !== 4'b0000) begin
      errors++;
      $display("FAIL t2_level: got %b expected 0000", blvl);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(4'b0101);
    t0 = cyc + 1;
    hold(4'b0101, 450);
    d = first_pulse[0] - t0;
    checks++;
    if (pcount[0] !== 1 || d !== 202) begin
      errors++;
      $display("FAIL t3_b0: got %0d pulses at +%0d expected 1 at +202",
               pcount[0], d);
    end
    d = first_pulse[2] - first_pulse[0];
    checks++;
    if (pcount[2] !== 1 || d !== 201) begin
      errors++;
      $display("FAIL t3_b2: got %0d pulses at +%0d expected 1 at +201",
               pcount[2], d);
    end
    checks++;
    if (blvl !== 4'b0101) begin
      errors++;
      $display("FAIL t3_level: got %b expected 0101", blvl);
    end
    checks++;
    if (gidx !== 2'd2) begin
      errors++;
      $display("FAIL t3_gidx: got %0d expected 2", gidx);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    step(4'b1010);
    t0 = cyc + 1;
    hold(4'b1010, 2);
    hold(4'b1000, 3);
    for (int p = 0; p < 89; p++) begin
      hold(4'b1010, 3);
      hold(4'b1000, 3);
    end
    d = first_pulse[3] - t0;
    checks++;
    if (pcount[3] !== 1 || d <= 0 || d > 404) begin
      errors++;
      $display("FAIL t4_b3: got %0d pulses at +%0d expected 1 within 404",
               pcount[3], d);
    end
    checks++;
    if (pcount[1] !== 0) begin
      errors++;
      $display("FAIL t4_b1: got %0d pulses expected 0", pcount[1]);
    end
    checks++;
    if (blvl !== 4'b1000) begin
      errors++;
      $display("FAIL t4_level: got %b expected 1000", blvl);
    end
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    step(4'b0010);
    hold(4'b0010, 210);
    checks++;
    if (blvl !== 4'b0010) begin
      errors++;
      $display("FAIL t5_pre_level: got %b expected 0010", blvl);
    end
    step(4'b0011);
    t0 = cyc + 1;
    hold(4'b0011, 153);
    checks++;
    if (busy !== 1'b1 || gidx !== 2'd0) begin
      errors++;
      $display("FAIL t5_pre_busy: got busy=%b gidx=%0d expected 1,0",
               busy, gidx);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bout !== 4'b0000 || blvl !== 4'b0000) begin
      errors++;
      $display("FAIL t5_rst_outs: got out=%b lvl=%b expected 0000,0000",
               bout, blvl);
    end
    checks++;
    if (busy !== 1'b0 || gidx !== 2'd3) begin
      errors++;
      $display("FAIL t5_rst_state: got busy=%b gidx=%0d expected 0,3",
               busy, gidx);
    end
    checks++;
    if (pcount[0] !== 0) begin
      errors++;
      $display("FAIL t5_no_pulse: got %0d pulses expected 0", pcount[0]);
    end
    hold(4'b0011, 3);
    reset = 1'b0;
    clear_rec();
    t0 = cyc + 1;
    hold(4'b0011, 450);
    d = first_pulse[0] - t0;
    checks++;
    if (pcount[0] !== 1 || d !== 202) begin
      errors++;
      $display("FAIL t5_recommit: got %0d pulses at +%0d expected 1 at +202",
               pcount[0], d);
    end
    checks++;
    if (blvl !== 4'b0011) begin
      errors++;
      $display("FAIL t5_level: got %b expected 0011", blvl);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    step(4'b0100);
    step(4'b0000);
    hold(4'b0000, 20);
    checks++;
    if (busy_cnt !== 1) begin
      errors++;
      $display("FAIL t6_busy: got %0d busy cycles expected 1", busy_cnt);
    end
    d = pcount[0] + pcount[1] + pcount[2] + pcount[3];
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL t6_pulses: got %0d expected 0", d);
    end
    checks++;
    if (blvl !== 4'b0000) begin
      errors++;
      $display("FAIL t6_level: got %b expected 0000", blvl);
    end
    checks++;
    if (gidx !== 2'd2) begin
      errors++;
      $display("FAIL t6_gidx: got %0d expected 2", gidx);
    end
  endtask

  initial begin
    reset = 1'b1;
    btn = 4'b0000;
    test_reset();
    test_press_bounce();
    test_release_bounce();
    test_simultaneous();
    test_fairness();
    test_reset_mid_track();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
